sc_hex_decoder: RTL
===================

# sc_hex_decoder

Receive-side counterpart to the stream-cipher encrypt path. It consumes the ASCII-hex digit stream that the encryptor emits (MS nibble first, then LS nibble). It pairs the digits into ciphertext bytes, XORs each byte with a locally generated 32-bit LFSR keystream, and buffers the recovered plaintext in a small FIFO with a valid/ready output. It sits between the UART receive buffer and any plaintext consumer, such as a print buffer or LED/status logic.

## Interface
- FIFO_DEPTH, 8, plaintext FIFO entries; power of two, minimum 2.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_ld  in  1  load `key` into the LFSR this cycle.
- key  in  32  keystream seed.
- in_vld  in  1  `in_char` valid this cycle.
- in_char  in  8  ASCII character from the encryptor stream.
- in_eol  in  1  end of message (carriage return seen).
- out_vld  out  1  FIFO head valid.
- out_byte  out  8  FIFO head (show-ahead).
- out_rdy  in  1  consumer pops the head when `out_vld & out_rdy`.
- err_hex  out  1  one-cycle pulse: a non-hex character was received.
- err_odd  out  1  one-cycle pulse: `in_eol` arrived with a dangling MS nibble.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- FSM states:
  - NOKEY: after reset.
  - WAIT_HI: holding no nibble.
  - WAIT_LO: MS nibble held.
- Transitions:
  - `key_ld` moves any state to WAIT_HI, loads the LFSR, and discards any held nibble.
  - NOKEY ignores `in_vld`, raises no errors and stays in NOKEY until `key_ld`.
  - WAIT_HI with a valid hex digit latches `hi`, then goes to WAIT_LO.
  - WAIT_LO with a valid hex digit forms `{hi, lo}` and returns to WAIT_HI.
  - `in_eol` in WAIT_LO pulses `err_odd`, drops `hi` and goes to WAIT_HI.
  - `in_eol` in WAIT_HI is a no-op.
- Hex set: '0'–'9', 'A'–'F', 'a'–'f'. Any other character with `in_vld` pulses `err_hex`, is ignored, and leaves the state unchanged.
- Priority: `key_ld` > `in_eol` > `in_vld`. A lower-priority event in the same cycle is discarded.
- LFSR (Fibonacci, x^32+x^22+x^2+x+1): `next = {s[30:0], s[31]^s[21]^s[1]^s[0]}`.
  - The keystream byte is `s[7:0]` before the step.
  - Exactly one step per completed ciphertext byte, including bytes dropped on overflow, so the keystream stays in sync with the encryptor.
  - An all-zero key is loaded as-is; the keystream is then constant 0 (pass-through).
- Plaintext = `{hi, lo} ^ s[7:0]`. It is pushed to the FIFO at the same edge that accepts the LS digit.
- FIFO push and pop:
  - Full with no pop in the same cycle: the push is dropped and `overflow` is set.
  - Full with a pop in the same cycle: the push is accepted.
  - Empty: `out_vld`=0 and `out_byte` holds its last value.
- `overflow` clears only on `rst`. `key_ld` does not flush the FIFO.

## Timing
- Reset values: `out_vld`=0, `out_byte`=0, `err_hex`=0, `err_odd`=0, `overflow`=0, `fifo_cnt`=0, state NOKEY, LFSR=0.
- Latency: the LS digit is accepted at cycle t; `out_vld`/`out_byte` are valid in cycle t+1.
- `err_hex` and `err_odd` are registered: asserted for exactly one cycle, the cycle after the offending input.
- Throughput: one digit per cycle sustained; one plaintext byte every 2 digit cycles.
- Back-to-back: a pop and a push in the same cycle leave `fifo_cnt` unchanged.
- `rst` mid-message: all state returns to reset values next cycle; the LFSR needs a new `key_ld`.

## Configuration
- `SC_DEC_PRINTABLE_EN` defined: any plaintext outside 0x20–0x7E is replaced by 0x2E ('.') before the FIFO push.
- Not defined: raw plaintext is pushed unchanged.
- The LFSR step is identical either way.

## Structure
- Shared package `sc_pkg`:
  - ASCII constants ('0', '9', 'A', 'F', 'a', 'f', CR, '.').
  - LFSR tap positions and width constant 32.
  - State enum {NOKEY, WAIT_HI, WAIT_LO}.
  - Hex-to-nibble function.
- Sub-module `sc_keystream`: 32-bit LFSR with load/step/byte output, reusable by the encrypt path.
- The FIFO is inline: pointers plus count.

## Test plan
- Key 0x00000001, stream "49","6A" -> `out_byte` 0x48 ('H') then 0x69 ('i'); LFSR states 0x1, 0x3, 0x6.
- Key 0x00000000, stream "41" -> 0x41; "z" mid-pair -> `err_hex` pulse, pair then completes normally.
- Key 0x00000001, "4" then `in_eol` -> `err_odd` pulse, nothing pushed; next "49" -> 0x48, because the LFSR did not step.
- `out_rdy`=0, key 0, nine pairs "30".."38" -> `fifo_cnt`=8, `overflow`=1; drain yields 0x30..0x37.
- `key_ld` and `in_vld` in the same cycle while in WAIT_LO -> the character is discarded, state is WAIT_HI and the held nibble is lost.
- Key 0, "07" -> 0x2E with `SC_DEC_PRINTABLE_EN` defined, 0x07 without it; `rst` mid-pair -> all outputs return to reset values.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared constants, state encoding and hex helpers for the stream-cipher
// encrypt/decrypt paths.
package sc_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_UF    = 8'h46;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LF    = 8'h66;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  // Fibonacci taps for x^32 + x^22 + x^2 + x + 1.
  localparam int LFSR_W     = 32;
  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;
  localparam int LFSR_TAP_D = 0;

  typedef enum logic [1:0] {
    NOKEY   = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } dec_state_e;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= ASCII_0)  && (c <= ASCII_9))  ||
           ((c >= ASCII_UA) && (c <= ASCII_UF)) ||
           ((c >= ASCII_LA) && (c <= ASCII_LF));
  endfunction

  function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
    logic [7:0] v;
    v = 8'h00;
    if ((c >= ASCII_0) && (c <= ASCII_9))        v = c - ASCII_0;
    else if ((c >= ASCII_UA) && (c <= ASCII_UF)) v = c - ASCII_UA + 8'd10;
    else if ((c >= ASCII_LA) && (c <= ASCII_LF)) v = c - ASCII_LA + 8'd10;
    return v[3:0];
  endfunction

  function automatic logic [7:0] to_printable(input logic [7:0] b);
    return ((b >= ASCII_SPACE) && (b <= ASCII_TILDE)) ? b : ASCII_DOT;
  endfunction

endpackage

// File: rtl/sc_keystream.sv
// 32-bit Fibonacci LFSR keystream generator; shared by the encrypt and
// decrypt paths so both sides step identically.
module sc_keystream
  import sc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [7:0]        ks_byte
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              feedback;

  // An all-zero seed is loaded unchanged and simply locks the keystream at 0.
  always_comb begin
    feedback = lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B] ^
               lfsr_q[LFSR_TAP_C] ^ lfsr_q[LFSR_TAP_D];
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = seed;
    else if (step) lfsr_d = {lfsr_q[LFSR_W-2:0], feedback};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign ks_byte = lfsr_q[7:0];

endmodule

// File: rtl/sc_hex_decoder.sv
// Hex-digit stream to plaintext decoder with keystream XOR and show-ahead FIFO.
// Define SC_DEC_PRINTABLE_EN to replace non-printable plaintext with '.'.
module sc_hex_decoder
  import sc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_ld,
  input  logic [31:0]                 key,
  input  logic                        in_vld,
  input  logic [7:0]                  in_char,
  input  logic                        in_eol,
  output logic                        out_vld,
  output logic [7:0]                  out_byte,
  input  logic                        out_rdy,
  output logic                        err_hex,
  output logic                        err_odd,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  dec_state_e state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic       err_hex_q, err_hex_d;
  logic       err_odd_q, err_odd_d;
  logic       overflow_q, overflow_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       char_hex;
  logic [3:0] char_nib;
  logic       take_hi;
  logic       byte_done;
  logic [7:0] ks_byte;
  logic [7:0] plain_byte;
  logic [7:0] push_byte;
  logic       full;
  logic       pop;
  logic       push;

  assign char_hex = is_hex(in_char);
  assign char_nib = hex_to_nibble(in_char);

  always_ff @(posedge clk) begin
    if (rst) state_q <= NOKEY;
    else     state_q <= state_d;
  end

  // key_ld wins over in_eol, which wins over in_vld.
  always_comb begin
    state_d = state_q;
    if (key_ld) begin
      state_d = WAIT_HI;
    end else begin
      case (state_q)
        NOKEY:   state_d = NOKEY;
        WAIT_HI: if (!in_eol && in_vld && char_hex) state_d = WAIT_LO;
        WAIT_LO: if (in_eol || (in_vld && char_hex)) state_d = WAIT_HI;
        default: state_d = NOKEY;
      endcase
    end
  end

  always_comb begin
    take_hi   = 1'b0;
    byte_done = 1'b0;
    err_hex_d = 1'b0;
    err_odd_d = 1'b0;
    if (!key_ld && (state_q != NOKEY)) begin
      if (in_eol) begin
        err_odd_d = (state_q == WAIT_LO);
      end else if (in_vld) begin
        err_hex_d = !char_hex;
        take_hi   = char_hex && (state_q == WAIT_HI);
        byte_done = char_hex && (state_q == WAIT_LO);
      end
    end
  end

  sc_keystream u_keystream (
    .clk     (clk),
    .rst     (rst),
    .load    (key_ld),
    .seed    (key),
    .step    (byte_done),
    .ks_byte (ks_byte)
  );

  assign plain_byte = {hi_q, char_nib} ^ ks_byte;

`ifdef SC_DEC_PRINTABLE_EN
  assign push_byte = to_printable(plain_byte);
`else
  assign push_byte = plain_byte;
`endif

  assign full = (cnt_q == FULL_CNT);
  assign pop  = out_vld && out_rdy;
  // A dropped byte still steps the LFSR so the keystream stays aligned.
  assign push = byte_done && (!full || pop);

  always_comb begin
    hi_d       = hi_q;
    if (key_ld || byte_done || (in_eol && state_q == WAIT_LO)) hi_d = 4'h0;
    else if (take_hi)                                          hi_d = char_nib;
    overflow_d = overflow_q || (byte_done && full && !pop);
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = push_byte;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    // Registered head; a byte written this edge into the new head slot bypasses mem.
    out_byte_d = out_byte_q;
    if (cnt_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) out_byte_d = push_byte;
      else                                out_byte_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= 4'h0;
      err_hex_q  <= 1'b0;
      err_odd_q  <= 1'b0;
      overflow_q <= 1'b0;
      out_byte_q <= 8'h00;
      mem_q      <= '{default: 8'h00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      hi_q       <= hi_d;
      err_hex_q  <= err_hex_d;
      err_odd_q  <= err_odd_d;
      overflow_q <= overflow_d;
      out_byte_q <= out_byte_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_vld  = (cnt_q != '0);
  assign out_byte = out_byte_q;
  assign err_hex  = err_hex_q;
  assign err_odd  = err_odd_q;
  assign overflow = overflow_q;
  assign fifo_cnt = cnt_q;

endmodule
